// File: rtl/uxn_mem_pkg.sv
// Shared types and default widths for the uxn main-memory arbiter.
package uxn_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // Arbiter sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    F_ISSUE,
    F_CAPT,
    D_HI,
    D_LO,
    D_CAPT_HI,
    D_CAPT_LO
  } arb_state_t;

  // Requester identity, used for round-robin bookkeeping.
  typedef enum logic {
    FETCH,
    DATA
  } port_id_t;

endpackage

// File: rtl/uxn_mem_arbiter.sv
// Shares the byte-wide main memory between the instruction-fetch port and the
// data port. Short accesses are split into two big-endian byte cycles, and
// contended requests are granted round-robin. Every output is registered.
module uxn_mem_arbiter
  import uxn_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  output logic                f_ack,
  output logic [DATA_W-1:0]   f_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic                d_short,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [2*DATA_W-1:0] d_wdata,
  output logic                d_ack,
  output logic [2*DATA_W-1:0] d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  arb_state_t          state;
  port_id_t            last_grant;
  logic                op_we;
  logic                op_short;
  logic [ADDR_W-1:0]   op_lo_addr;
  logic [DATA_W-1:0]   op_lo_data;
  logic [DATA_W-1:0]   hi_byte;

  // Single sequencing FSM: arbitrate in IDLE, then walk the byte cycles of the
  // granted access. The data request is captured at grant so the second byte
  // cycle does not depend on the requester keeping its inputs up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= DATA;
      op_we      <= 1'b0;
      op_short   <= 1'b0;
      op_lo_addr <= '0;
      op_lo_data <= '0;
      hi_byte    <= '0;
      f_ack      <= 1'b0;
      f_rdata    <= '0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          // An ack still high means its requester may not have dropped req
          // yet, so this cycle is left without a grant.
          if (!f_ack && !d_ack) begin
            if (f_req && (!d_req || last_grant == DATA)) begin
              state      <= F_ISSUE;
              busy       <= 1'b1;
              last_grant <= FETCH;
              mem_en     <= 1'b1;
              mem_we     <= 1'b0;
              mem_addr   <= f_addr;
            end else if (d_req) begin
              state      <= D_HI;
              busy       <= 1'b1;
              last_grant <= DATA;
              op_we      <= d_we;
              op_short   <= d_short;
              op_lo_addr <= d_addr + 1'b1;
              op_lo_data <= d_wdata[DATA_W-1:0];
              mem_en     <= 1'b1;
              mem_we     <= d_we;
              mem_addr   <= d_addr;
              mem_wdata  <= d_short ? d_wdata[2*DATA_W-1:DATA_W]
                                    : d_wdata[DATA_W-1:0];
            end
          end
        end

        F_ISSUE: begin
          mem_en <= 1'b0;
          state  <= F_CAPT;
        end

        F_CAPT: begin
          f_rdata <= mem_rdata;
          f_ack   <= 1'b1;
          state   <= IDLE;
          busy    <= 1'b0;
        end

        D_HI: begin
          if (op_short) begin
            state     <= D_LO;
            mem_addr  <= op_lo_addr;
            mem_wdata <= op_lo_data;
          end else if (op_we) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            d_ack  <= 1'b1;
            state  <= IDLE;
            busy   <= 1'b0;
          end else begin
            mem_en <= 1'b0;
            state  <= D_CAPT_LO;
          end
        end

        D_LO: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (op_we) begin
            d_ack <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hi_byte <= mem_rdata;
            state   <= D_CAPT_HI;
          end
        end

        // The high byte was latched on entry; the low byte is on mem_rdata now.
        D_CAPT_HI: begin
          d_rdata <= {hi_byte, mem_rdata};
          d_ack   <= 1'b1;
          state   <= IDLE;
          busy    <= 1'b0;
        end

        D_CAPT_LO: begin
          d_rdata <= {{DATA_W{1'b0}}, mem_rdata};
          d_ack   <= 1'b1;
          state   <= IDLE;
          busy    <= 1'b0;
        end

        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= IDLE;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uxn_mem_arbiter.sv
// Bench for uxn_mem_arbiter: a behavioural 64 KiB memory with one-cycle read
// latency, directed tests plus randomized traffic, checked against a byte-array
// reference of memory and a round-robin/latency model of the arbiter.
module tb_uxn_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_ack;
  logic [7:0]  f_rdata;
  logic        d_req;
  logic        d_we;
  logic        d_short;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  logic [7:0]  mem [0:65535];
  logic        mem_loaded = 1'b0;
  int          mem_reads = 0;

  logic [7:0]  ref_mem [0:65535];
  bit          m_last_data;
  logic [15:0] m_d_rdata;

  int errors = 0;
  int checks = 0;

  uxn_mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_ack     (f_ack),
    .f_rdata   (f_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_short   (d_short),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // uxn_mem_model: preloads a known pattern, then serves one access per
  // strobed edge with the read byte appearing in the following cycle.
  always @(posedge clk) begin : uxn_mem_model
    if (!mem_loaded) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_byte(16'(i));
      mem_loaded <= 1'b1;
    end
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr];
        mem_reads <= mem_reads + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raises the requested ports together and records the edge (counted from
  // the first edge after the request) on which each ack becomes visible.
  task automatic applyStimulus(input bit use_f, input bit use_d, input logic [15:0] fa,
                               input logic dwe, input logic dsh, input logic [15:0] da,
                               input logic [15:0] dwd, output int fe, output int de,
                               output logic [7:0] fd, output logic [15:0] dd);
    bit f_pend, d_pend;
    fe = -1; de = -1; fd = 8'h00; dd = 16'h0000;
    @(negedge clk);
    f_req = use_f; f_addr = fa;
    d_req = use_d; d_we = dwe; d_short = dsh; d_addr = da; d_wdata = dwd;
    f_pend = use_f; d_pend = use_d;
    for (int e = 1; e <= 40 && (f_pend || d_pend); e++) begin
      @(negedge clk);
      if (f_pend && f_ack) begin fe = e; fd = f_rdata; f_pend = 1'b0; f_req = 1'b0; end
      if (d_pend && d_ack) begin de = e; dd = d_rdata; d_pend = 1'b0; d_req = 1'b0; end
    end
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
  endtask

  // Reference behaviour: the waiting port is served after the winner's ack
  // plus one dead cycle; latencies come from the access type.
  task automatic runTransaction(input string tag, input bit use_f, input bit use_d,
                                input logic [15:0] fa, input logic dwe, input logic dsh,
                                input logic [15:0] da, input logic [15:0] dwd,
                                output logic [15:0] d_out);
    int fe, de, exp_fe, exp_de, lf, ld;
    logic [7:0] fd, exp_fd;
    logic [15:0] dd, exp_dd, da1;
    da1 = da + 16'd1;
    lf = 2;
    ld = dwe ? (dsh ? 2 : 1) : (dsh ? 3 : 2);
    exp_fe = 0; exp_de = 0;
    exp_fd = ref_mem[fa];
    exp_dd = m_d_rdata;
    if (use_d && !dwe) exp_dd = dsh ? {ref_mem[da], ref_mem[da1]} : {8'h00, ref_mem[da]};
    if (use_f && use_d) begin
      if (m_last_data) begin
        exp_fe = 1 + lf; exp_de = exp_fe + 2 + ld; m_last_data = 1'b1;
      end else begin
        exp_de = 1 + ld; exp_fe = exp_de + 2 + lf; m_last_data = 1'b0;
      end
    end else if (use_f) begin
      exp_fe = 1 + lf; m_last_data = 1'b0;
    end else begin
      exp_de = 1 + ld; m_last_data = 1'b1;
    end
    applyStimulus(use_f, use_d, fa, dwe, dsh, da, dwd, fe, de, fd, dd);
    if (use_f) begin
      checkOutput({tag, " f_ack edge"}, fe, exp_fe);
      checkOutput({tag, " f_rdata"}, {24'h0, fd}, {24'h0, exp_fd});
    end
    if (use_d) begin
      checkOutput({tag, " d_ack edge"}, de, exp_de);
      checkOutput({tag, " d_rdata"}, {16'h0, dd}, {16'h0, exp_dd});
      m_d_rdata = exp_dd;
      if (dwe) begin
        if (dsh) begin ref_mem[da] = dwd[15:8]; ref_mem[da1] = dwd[7:0]; end
        else ref_mem[da] = dwd[7:0];
      end
    end
    d_out = dd;
  endtask

  initial begin
    logic [15:0] dout, ra, rw;
    int reads0, mism;
    bit rwe, rsh;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
    m_last_data = 1'b1;
    m_d_rdata = 16'h0000;
    rst = 1'b0;
    f_req = 1'b0; f_addr = 16'h0;
    d_req = 1'b0; d_we = 1'b0; d_short = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst mem_addr", {16'h0, mem_addr}, 32'h0);
    checkOutput("rst mem ctrl", {22'h0, mem_en, mem_we, mem_wdata}, 32'h0);
    checkOutput("rst acks busy", {29'h0, f_ack, d_ack, busy}, 32'h0);
    checkOutput("rst rdata", {8'h0, f_rdata, d_rdata}, 32'h0);
    rst = 1'b0;
    $display("[TB] contended pairs after reset");
    for (int i = 0; i < 10; i++) begin
      runTransaction("pair", 1'b1, 1'b1, 16'($urandom_range(0, 16'h7FFF)), 1'($urandom),
                     1'($urandom), 16'($urandom_range(16'h8000, 16'hFFFE)), 16'($urandom), dout);
    end
    $display("[TB] single fetch");
    runTransaction("t1 setup", 1'b0, 1'b1, 16'h0, 1'b1, 1'b0, 16'h0100, 16'h7780, dout);
    reads0 = mem_reads;
    runTransaction("t1 fetch", 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 16'h0, 16'h0, dout);
    checkOutput("t1 f_rdata", {24'h0, f_rdata}, 32'h80);
    checkOutput("t1 read count", mem_reads - reads0, 1);
    runTransaction("pair after fetch", 1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h9000, 16'h0, dout);
    $display("[TB] wrapping short write and read");
    runTransaction("t3 short write", 1'b0, 1'b1, 16'h0, 1'b1, 1'b1, 16'hFFFF, 16'h1234, dout);
    checkOutput("t3 mem[FFFF]", {24'h0, mem[16'hFFFF]}, 32'h12);
    checkOutput("t3 mem[0000]", {24'h0, mem[16'h0000]}, 32'h34);
    runTransaction("t4 short read", 1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 16'hFFFF, 16'h0, dout);
    checkOutput("t4 short value", {16'h0, dout}, 32'h1234);
    runTransaction("t4 byte read", 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0000, 16'h0, dout);
    checkOutput("t4 byte value", {16'h0, dout}, 32'h0034);
    repeat (2) @(negedge clk);
    checkOutput("t4 d_rdata hold", {16'h0, d_rdata}, 32'h0034);
    $display("[TB] byte write");
    runTransaction("t5 byte write", 1'b0, 1'b1, 16'h0, 1'b1, 1'b0, 16'h0200, 16'hAB5C, dout);
    checkOutput("t5 mem[0200]", {24'h0, mem[16'h0200]}, 32'h5C);
    checkOutput("t5 mem[0201]", {24'h0, mem[16'h0201]}, {24'h0, ref_mem[16'h0201]});
    $display("[TB] random traffic");
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom); rw = 16'($urandom); rwe = 1'($urandom); rsh = 1'($urandom);
      if ($urandom_range(0, 2) == 0)
        runTransaction("rand fetch", 1'b1, 1'b0, ra, 1'b0, 1'b0, 16'h0, 16'h0, dout);
      else
        runTransaction("rand data", 1'b0, 1'b1, 16'h0, rwe, rsh, ra, rw, dout);
    end
    $display("[TB] reset during second byte of short write");
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_short = 1'b1; d_addr = 16'h0300; d_wdata = 16'hC3A5;
    repeat (2) @(negedge clk);
    checkOutput("t6 low addr", {16'h0, mem_addr}, 32'h0301);
    checkOutput("t6 busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("t6 rst mem_addr", {16'h0, mem_addr}, 32'h0);
    checkOutput("t6 rst mem ctrl", {22'h0, mem_en, mem_we, mem_wdata}, 32'h0);
    checkOutput("t6 rst acks busy", {29'h0, f_ack, d_ack, busy}, 32'h0);
    checkOutput("t6 rst rdata", {8'h0, f_rdata, d_rdata}, 32'h0);
    d_req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t6 mem[0300]", {24'h0, mem[16'h0300]}, 32'hC3);
    checkOutput("t6 mem[0301]", {24'h0, mem[16'h0301]}, {24'h0, ref_mem[16'h0301]});
    ref_mem[16'h0300] = 8'hC3;
    m_last_data = 1'b1;
    m_d_rdata = 16'h0000;
    rst = 1'b0;
    runTransaction("t6 pair", 1'b1, 1'b1, 16'h0400, 1'b0, 1'b0, 16'hA000, 16'h0, dout);
    mism = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) mism++;
    checkOutput("memory image", mism, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
